// File: rtl/fetch_seq_pkg.sv
// Shared constants and types for the multi-cycle instruction-fetch controller.
package fetch_seq_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
    } fetchEntry_t;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/PC_Adder.sv
// Plain 32-bit adder used for the sequential fetch PC; wraps modulo 2^32.
module PC_Adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = a + b;

endmodule

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched instruction that arrived while decode was stalled.
module fetch_skid_buf
    import fetch_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  fetchEntry_t din,
    output fetchEntry_t dout,
    output logic        valid
);

    fetchEntry_t entryQ;
    logic        validQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entryQ <= '0;
            validQ <= 1'b0;
        end else if (clear || drain) begin
            entryQ <= '0;
            validQ <= 1'b0;
        end else if (load) begin
            entryQ <= din;
            validQ <= 1'b1;
        end
    end

    assign dout  = entryQ;
    assign valid = validQ;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the fetch PC, one outstanding imem request, stale-response
// dropping after redirects, a skid slot for decode back-pressure, and the IF/ID register.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    logic [1:0]  stateQ, stateD;
    logic [31:0] pc_q, pcD;
    logic        drop_q, dropD;
    logic [31:0] pcPlus4;

    logic        skidLoad, skidDrain, skidClear, skidValid;
    fetchEntry_t skidOut, newEntry;

    logic        ifidLoad;
    fetchEntry_t ifidIn;
    logic        ifidFree;

    PC_Adder u_pcAdder (
        .a(pc_q),
        .b(32'd4),
        .y(pcPlus4)
    );

    fetch_skid_buf u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skidLoad),
        .drain(skidDrain),
        .clear(skidClear),
        .din  (newEntry),
        .dout (skidOut),
        .valid(skidValid)
    );

    assign newEntry  = '{instr: imem_rdata, pc: pc_q, pcPlus4: pcPlus4};
    assign ifidFree  = !ValidD || !StallD;
    assign imem_req  = (stateQ == REQ);
    assign imem_addr = imem_req ? {pc_q[31:2], 2'b00} : 32'h0;

    always_comb begin
        stateD    = stateQ;
        pcD       = pc_q;
        dropD     = drop_q;
        skidLoad  = 1'b0;
        skidDrain = 1'b0;
        skidClear = 1'b0;
        ifidLoad  = 1'b0;
        ifidIn    = newEntry;

        case (stateQ)
            IDLE: stateD = REQ;
            REQ: begin
                if (imem_gnt) stateD = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        dropD  = 1'b0;
                        stateD = REQ;
                    end else if (ifidFree) begin
                        ifidLoad = 1'b1;
                        pcD      = pcPlus4;
                        stateD   = REQ;
                    end else begin
                        skidLoad = 1'b1;
                        pcD      = pcPlus4;
                        stateD   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!StallD) begin
                    skidDrain = 1'b1;
                    ifidLoad  = skidValid;
                    ifidIn    = skidOut;
                    stateD    = REQ;
                end
            end
            default: stateD = IDLE;
        endcase

        // A redirect overrides everything; a request already granted must have its reply dropped.
        if (PCSrcE) begin
            pcD       = wordAlign(PCTargetE);
            skidLoad  = 1'b0;
            skidDrain = 1'b0;
            skidClear = 1'b1;
            ifidLoad  = 1'b0;
            dropD     = 1'b0;
            case (stateQ)
                REQ: begin
                    if (imem_gnt) begin
                        dropD  = 1'b1;
                        stateD = WAIT;
                    end else begin
                        stateD = REQ;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        stateD = REQ;
                    end else begin
                        dropD  = 1'b1;
                        stateD = WAIT;
                    end
                end
                default: stateD = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= IDLE;
            pc_q   <= RESET_PC;
            drop_q <= 1'b0;
        end else begin
            stateQ <= stateD;
            pc_q   <= pcD;
            drop_q <= dropD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (PCSrcE) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (ifidLoad) begin
            InstrD   <= ifidIn.instr;
            PCD      <= ifidIn.pc;
            PCPlus4D <= ifidIn.pcPlus4;
            ValidD   <= 1'b1;
        end else if (!StallD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed per-cycle vector bench for fetch_sequencer plus hand-written reset/wrap sequences.
module tb_fetch_sequencer;

    typedef struct {
        logic        srcE;
        logic [31:0] tgt;
        logic        stall;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pcd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        StallD = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
    logic        ValidD;

    logic        rst2 = 1'b0;
    logic        stall2 = 1'b0;
    logic        gnt2 = 1'b0;
    logic        rv2 = 1'b0;
    logic [31:0] rd2 = '0;
    logic        req2;
    logic [31:0] addr2, instr2, pcd2, p4d2;
    logic        vld2;

    int nVec = 0;
    int nMis = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2), .PCSrcE(1'b0), .PCTargetE(32'h0), .StallD(stall2),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
        .imem_rvalid(rv2), .imem_rdata(rd2), .InstrD(instr2), .PCD(pcd2),
        .PCPlus4D(p4d2), .ValidD(vld2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic srcE, input logic [31:0] tgt, input logic stall,
                                input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                input logic req, input logic [31:0] addr, input logic vld,
                                input logic [31:0] instr, input logic [31:0] pcd);
        vec_t v;
        v.srcE = srcE; v.tgt = tgt; v.stall = stall; v.gnt = gnt; v.rvalid = rvalid;
        v.rdata = rdata; v.req = req; v.addr = addr; v.vld = vld; v.instr = instr; v.pcd = pcd;
        return v;
    endfunction

    localparam logic [31:0] I0 = 32'h0010_0093, I1 = 32'h0020_0113, I2 = 32'h0030_0193;
    localparam logic [31:0] I3 = 32'h0040_0213, I4 = 32'h0050_0293, I5 = 32'h0060_0313;
    localparam logic [31:0] I6 = 32'h0070_0393, I7 = 32'h0080_0413, I8 = 32'h0090_0493;
    localparam logic [31:0] I9 = 32'h00A0_0513, I10 = 32'h00B0_0593, I11 = 32'h00C0_0613;
    localparam logic [31:0] J0 = 32'h0AA0_0013, J1 = 32'h0BB0_0013;

    initial begin
        // srcE tgt stall gnt rv rdata | req addr vld instr pcd
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0,     0, 0,   0));     // IDLE
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 0, 1, I0,           0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 4,     1, I0,  0));
        vecs.push_back(mk(0, 0, 0, 0, 1, I1,           0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 8,     1, I1,  4));
        vecs.push_back(mk(0, 0, 0, 0, 1, I2,           0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'hC,   1, I2,  8));
        vecs.push_back(mk(0, 0, 0, 0, 1, I3,           0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 'h10,  1, I3,  'hC));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'hDEADBEEF,   1, 'h10,  0, 0,   0));   // rvalid in REQ
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 'h10,  0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h10,  0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            0, 0,     0, 0,   0));   // gnt in WAIT
        vecs.push_back(mk(0, 0, 0, 0, 1, I4,           0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 'h14,  1, I4,  'h10));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h14,  0, 0,   0));
        vecs.push_back(mk(1, 'h100, 0, 0, 0, 0,        0, 0,     0, 0,   0));   // redirect in WAIT
        vecs.push_back(mk(0, 0, 0, 0, 1, 'hBAD0BAD0,   0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h100, 0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 0, 1, I5,           0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h104, 1, I5,  'h100));
        vecs.push_back(mk(0, 0, 0, 0, 1, I6,           0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,            1, 'h108, 1, I6,  'h104)); // stall
        vecs.push_back(mk(0, 0, 1, 0, 1, I7,           0, 0,     1, I6,  'h104));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,            0, 0,     1, I6,  'h104));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,            0, 0,     1, I6,  'h104));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0,     1, I6,  'h104));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 'h10C, 1, I7,  'h108));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h10C, 0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 0, 1, I8,           0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,            1, 'h110, 1, I8,  'h10C));
        vecs.push_back(mk(0, 0, 1, 0, 1, I9,           0, 0,     1, I8,  'h10C));
        vecs.push_back(mk(1, 'h203, 1, 0, 0, 0,        0, 0,     1, I8,  'h10C)); // redirect in HOLD
        vecs.push_back(mk(1, 'h300, 1, 1, 0, 0,        1, 'h200, 0, 0,   0));   // redirect with gnt
        vecs.push_back(mk(0, 0, 0, 0, 1, 'hBAD1,       0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h300, 0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 0, 1, I10,          0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 'h304, 1, I10, 'h300));
        vecs.push_back(mk(1, 'h400, 0, 0, 0, 0,        1, 'h304, 0, 0,   0));   // redirect in REQ
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h400, 0, 0,   0));
        vecs.push_back(mk(1, 'h500, 0, 0, 1, 'hBAD2,   0, 0,     0, 0,   0));   // redirect with rvalid
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h500, 0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 0, 1, I11,          0, 0,     0, 0,   0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 'h504, 1, I11, 'h500));

        repeat (2) @(negedge clk);
        #1;
        nVec++;
        chk("reset_req", {31'b0, imem_req}, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_valid", {31'b0, ValidD}, 32'h0);
        chk("reset_instr", InstrD, 32'h0);
        chk("reset_pcd", PCD, 32'h0);
        chk("reset_pcplus4", PCPlus4D, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            PCSrcE      = vecs[i].srcE;
            PCTargetE   = vecs[i].tgt;
            StallD      = vecs[i].stall;
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rvalid;
            imem_rdata  = vecs[i].rdata;
            #1;
            nVec++;
            chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
            if (vecs[i].req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_valid", i), {31'b0, ValidD}, {31'b0, vecs[i].vld});
            chk($sformatf("v%0d_instr", i), InstrD, vecs[i].instr);
            if (vecs[i].vld) begin
                chk($sformatf("v%0d_pcd", i), PCD, vecs[i].pcd);
                chk($sformatf("v%0d_pcplus4", i), PCPlus4D, vecs[i].pcd + 32'd4);
            end
            @(negedge clk);
        end
        PCSrcE = 0; StallD = 0; imem_gnt = 0; imem_rvalid = 0;

        // Wrap-around reset PC and asynchronous reset in the middle of WAIT.
        rst2 = 1'b1;
        #1; nVec++;
        chk("w_idle_req", {31'b0, req2}, 32'h0);
        @(negedge clk); gnt2 = 1;
        #1; nVec++;
        chk("w_req0", {31'b0, req2}, 32'h1);
        chk("w_addr0", addr2, 32'hFFFF_FFF8);
        @(negedge clk); gnt2 = 0; rv2 = 1; rd2 = J0;
        #1; nVec++;
        chk("w_wait0_req", {31'b0, req2}, 32'h0);
        @(negedge clk); rv2 = 0; gnt2 = 1;
        #1; nVec++;
        chk("w_addr1", addr2, 32'hFFFF_FFFC);
        chk("w_valid1", {31'b0, vld2}, 32'h1);
        chk("w_instr1", instr2, J0);
        chk("w_pcd1", pcd2, 32'hFFFF_FFF8);
        chk("w_p4_1", p4d2, 32'hFFFF_FFFC);
        @(negedge clk); gnt2 = 0; rv2 = 1; rd2 = J1;
        #1; nVec++;
        chk("w_bubble", {31'b0, vld2}, 32'h0);
        @(negedge clk); rv2 = 0; gnt2 = 1; stall2 = 1;
        #1; nVec++;
        chk("w_addr2", addr2, 32'h0);
        chk("w_instr2", instr2, J1);
        chk("w_pcd2", pcd2, 32'hFFFF_FFFC);
        chk("w_p4_2", p4d2, 32'h0);
        @(negedge clk); gnt2 = 0;
        #1; nVec++;
        chk("w_hold_valid", {31'b0, vld2}, 32'h1);
        chk("w_hold_req", {31'b0, req2}, 32'h0);
        rst2 = 1'b0;
        #1; nVec++;
        chk("w_rst_valid", {31'b0, vld2}, 32'h0);
        chk("w_rst_instr", instr2, 32'h0);
        chk("w_rst_pcd", pcd2, 32'h0);
        chk("w_rst_p4", p4d2, 32'h0);
        chk("w_rst_req", {31'b0, req2}, 32'h0);
        chk("w_rst_addr", addr2, 32'h0);
        @(negedge clk); rst2 = 1'b1; stall2 = 0;
        #1; nVec++;
        chk("w_restart_idle", {31'b0, req2}, 32'h0);
        @(negedge clk);
        #1; nVec++;
        chk("w_restart_req", {31'b0, req2}, 32'h1);
        chk("w_restart_addr", addr2, 32'hFFFF_FFF8);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch controller that sits between the execute-stage redirect (PCSrcE/PCTargetE), a handshaked instruction memory port and the IF/ID pipeline register. It owns the fetch PC, issues one outstanding memory request at a time, discards responses made stale by a branch redirect, absorbs decode back-pressure with a one-entry skid buffer, and drives InstrD/PCD/PCPlus4D with a valid bit. It replaces the single-cycle fetch path wherever instruction memory has variable latency.

## Interface

- RESET_PC, 32'h00000000, first fetch address after reset
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- PCSrcE  input  1  redirect request from execute, one-cycle pulse
- PCTargetE  input  32  redirect target, sampled when PCSrcE=1
- StallD  input  1  decode stall: hold IF/ID contents
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch address, bits [1:0] always 0
- imem_gnt  input  1  memory accepted request this cycle (sampled only when imem_req=1)
- imem_rvalid  input  1  response data valid, ≥1 cycle after gnt
- imem_rdata  input  32  response instruction word
- InstrD  output  32  IF/ID instruction; 32'h00000000 when ValidD=0
- PCD  output  32  IF/ID PC of InstrD
- PCPlus4D  output  32  PCD+4
- ValidD  output  1  IF/ID holds a live instruction

## Operation

- States: IDLE, REQ, WAIT, HOLD. Registers: pc_q, drop_q, skid (instr+pc), IF/ID (InstrD, PCD, PCPlus4D, ValidD).
- Reset (rst=0, async): state=IDLE, pc_q=RESET_PC, drop_q=0, all outputs 0, imem_req=0.
- IDLE: next edge → REQ unconditionally.
- REQ: imem_req=1, imem_addr={pc_q[31:2],2'b00}. Address may change before gnt; memory samples it only on the gnt cycle. gnt → WAIT.
- WAIT: imem_req=0. On rvalid: if drop_q, discard data, drop_q←0, → REQ. Else if IF/ID free (ValidD=0 or StallD=0): load IF/ID with rdata, pc_q, pc_q+4, ValidD=1; pc_q←pc_q+4; → REQ. Else: write skid, pc_q←pc_q+4, → HOLD.
- HOLD: imem_req=0. When StallD=0: skid → IF/ID, → REQ.
- Redirect (PCSrcE=1), highest priority after reset, any state: pc_q←PCTargetE; IF/ID flushed (ValidD←0, InstrD←0, PCD/PCPlus4D←0) regardless of StallD. REQ without gnt: stay REQ, new address next cycle. REQ with gnt same cycle, or WAIT without rvalid: drop_q←1, → WAIT. WAIT with rvalid same cycle: response discarded, → REQ. HOLD: skid discarded, → REQ.
- IF/ID with no new load, StallD=0, no redirect: ValidD←0, InstrD←0 (bubble). StallD=1: hold.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFFFFFC+4 wraps to 0. PCTargetE[1:0] ignored.
- rvalid outside WAIT and gnt outside REQ are ignored.

## Timing

- Reset release edge: IDLE→REQ; imem_req=1 from the following cycle with addr=RESET_PC.
- Zero-wait memory (gnt in first REQ cycle, rvalid next cycle): ValidD rises on the edge that samples rvalid; steady state one instruction per 2 cycles.
- Redirect to first request at target: same cycle if in REQ (addr combinational from pc_q next cycle), i.e. imem_addr=PCTargetE in the cycle after PCSrcE.
- At most one request outstanding; at most one instruction held outside IF/ID (skid).

## Structure

- Package fetch_seq_pkg: state enum (IDLE, REQ, WAIT, HOLD), NOP_INSTR=32'h00000000, RESET_PC default.
- Sub-module fetch_skid_buf: one-entry instr/PC buffer with load, drain, clear; FSM and IF/ID register stay in the top.
- Reuse existing PC_Adder for pc_q+4.

## Test plan

- Reset, zero-wait memory, StallD=0: imem_addr sequence 0,4,8,C; ValidD pulses with InstrD=mem[0..3], PCD=0,4,8,C, PCPlus4D=PCD+4.
- Gnt delayed 3 cycles, rvalid 2 cycles after gnt: imem_addr held at 4 during wait, single IF/ID load per request, no duplicate.
- PCSrcE=1, PCTargetE=32'h100 while WAIT on addr 8: response for 8 discarded, ValidD=0, next imem_addr=32'h100, ValidD next carries PCD=32'h100.
- StallD=1 for 4 cycles with IF/ID valid and a response arriving: IF/ID unchanged, skid filled, no new imem_req until StallD=0; then skid instr appears in InstrD.
- PCSrcE in HOLD and PCSrcE coincident with gnt: skid/stale data never reaches InstrD; fetch resumes at target.
- RESET_PC=32'hFFFFFFF8: addresses FFFFFFF8, FFFFFFFC, 00000000; rst pulled low mid-WAIT: all outputs 0 immediately, restart at RESET_PC.
